scope_capture: RTL and testbench



---
 rtl/scope_capture_pkg.sv | 22 ++
 rtl/scope_ram.sv | 30 +++
 rtl/scope_capture.sv | 187 ++++++++++++++++++
 tb/tb_scope_capture.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/scope_capture_pkg.sv
// Shared audio/scope definitions: capture state encoding, display sample width
// and the reduction from 24-bit codec samples to 8-bit offset-binary pixels.
package scope_capture_pkg;

   localparam int DISP_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_WAIT,
      ST_POST,
      ST_DONE
   } scope_state_e;

   // Keep the top byte and flip its sign bit: signed -128 -> 0, 0 -> 128.
   function automatic logic [DISP_W-1:0] to_disp(input logic [23:0] smp);
      logic unused_lsb;
      unused_lsb = ^smp[15:0];
      return {~smp[23], smp[22:16]};
   endfunction

endpackage

// File: rtl/scope_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port on
// the same clock. The read register resets so the display output starts at 0.
module scope_ram #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [1 << ADDR_W];
   logic [DATA_W-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_q <= '0;
      else     rd_q <= mem[rd_addr];
   end

   assign rd_data = rd_q;

endmodule

// File: rtl/scope_capture.sv
// Triggered capture of one display frame from the I2S sample stream; the frame
// is read back trigger-relative, index 0 being the oldest pre-trigger sample.
//
// state | meaning
// IDLE  | no capture since reset
// PRE   | storing the PRETRIG pre-trigger samples
// WAIT  | storing samples while looking for the trigger or the timeout
// POST  | storing the remainder of the frame after the trigger sample
// DONE  | frame held, no writes until re-armed
module scope_capture
   import scope_capture_pkg::*;
#(
   parameter int ADDR_W  = 9,
   parameter int PRETRIG = 64,
   parameter int TIMEOUT = 4095
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sampleclk,
   input  logic [23:0]       snd_l,
   input  logic [23:0]       snd_r,
   input  logic              ch_sel,
   input  logic [7:0]        trig_level,
   input  logic              trig_rising,
   input  logic              arm,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DISP_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              auto_trig
);

   localparam int DEPTH    = 1 << ADDR_W;
   localparam int POST_LEN = DEPTH - PRETRIG;
   localparam int TO_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);
   localparam logic [ADDR_W-1:0] PRE_LOAD  = ADDR_W'(PRETRIG - 1);
   localparam logic [ADDR_W-1:0] POST_LOAD = ADDR_W'(POST_LEN - 2);
   localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT);

   scope_state_e      state_q, state_d;
   logic              sync1_q, sync2_q, sync3_q;
   logic              tick_q, tick_d;
   logic [ADDR_W-1:0] wp_q, wp_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
   logic signed [7:0] prev_q, prev_d;
   logic              auto_q, auto_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [23:0]        sel;
   logic signed [7:0]  s8;
   logic signed [7:0]  lvl;
   logic               hit;
   logic               timed_out;
   logic               ram_we;
   logic [DISP_W-1:0]  ram_wdata;
   logic [ADDR_W-1:0]  rd_phys;

   always_comb begin
      state_d    = state_q;
      wp_d       = wp_q;
      cnt_d      = cnt_q;
      to_d       = to_q;
      trig_ptr_d = trig_ptr_q;
      prev_d     = prev_q;
      auto_d     = auto_q;
      ram_we     = 1'b0;

      tick_d    = sync2_q & ~sync3_q;
      sel       = ch_sel ? snd_r : snd_l;
      s8        = signed'(sel[23:16]);
      lvl       = signed'(trig_level);
      ram_wdata = to_disp(sel);
      hit       = trig_rising ? ((prev_q < lvl) && (s8 >= lvl))
                              : ((prev_q > lvl) && (s8 <= lvl));
      timed_out = (TIMEOUT != 0) && (to_q == '0);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // arm wins over a coincident tick; that tick is not stored
            if (arm) begin
               state_d = (PRETRIG == 0) ? ST_WAIT : ST_PRE;
               wp_d    = '0;
               cnt_d   = PRE_LOAD;
               to_d    = TO_LOAD;
               auto_d  = 1'b0;
            end
         end
         ST_PRE: begin
            if (tick_q) begin
               ram_we = 1'b1;
               wp_d   = wp_q + 1'b1;
               prev_d = s8;
               if (cnt_q == '0) begin
                  state_d = ST_WAIT;
                  to_d    = TO_LOAD;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (tick_q) begin
               ram_we = 1'b1;
               wp_d   = wp_q + 1'b1;
               prev_d = s8;
               if (hit || timed_out) begin
                  trig_ptr_d = wp_q;
                  auto_d     = ~hit;
                  cnt_d      = POST_LOAD;
                  state_d    = (POST_LEN == 1) ? ST_DONE : ST_POST;
               end else begin
                  to_d = to_q - 1'b1;
               end
            end
         end
         ST_POST: begin
            if (tick_q) begin
               ram_we = 1'b1;
               wp_d   = wp_q + 1'b1;
               if (cnt_q == '0) state_d = ST_DONE;
               else             cnt_d   = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = state_d inside {ST_PRE, ST_WAIT, ST_POST};
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         sync3_q    <= 1'b0;
         tick_q     <= 1'b0;
         wp_q       <= '0;
         cnt_q      <= '0;
         to_q       <= '0;
         trig_ptr_q <= '0;
         prev_q     <= '0;
         auto_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync1_q    <= sampleclk;
         sync2_q    <= sync1_q;
         sync3_q    <= sync2_q;
         tick_q     <= tick_d;
         wp_q       <= wp_d;
         cnt_q      <= cnt_d;
         to_q       <= to_d;
         trig_ptr_q <= trig_ptr_d;
         prev_q     <= prev_d;
         auto_q     <= auto_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign rd_phys = trig_ptr_q - PRE_OFS + rd_addr;

   scope_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DISP_W)
   ) u_ram (
      .clk     (clk),
      .rst     (reset),
      .we      (ram_we),
      .wr_addr (wp_q),
      .wr_data (ram_wdata),
      .rd_addr (rd_phys),
      .rd_data (rd_data)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign auto_trig = auto_q;

endmodule

// File: tb/tb_scope_capture.sv
// Bench for scope_capture: directed captures with a read-back scoreboard.
module tb_scope_capture;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sampleclk = 1'b0;
   logic [23:0] snd_l = '0;
   logic [23:0] snd_r = '0;
   logic        ch_sel = 1'b0;
   logic [7:0]  trig_level = '0;
   logic        trig_rising = 1'b1;
   logic        arm = 1'b0;
   logic        arm_w = 1'b0;
   logic [8:0]  rd_addr = '0;
   logic [7:0]  rd_data, rd_data_w;
   logic        busy, done, auto_trig;
   logic        busy_w, done_w, auto_trig_w;

   int n_chk = 0;
   int n_fail = 0;

   logic [17:0] exp_q [$];
   logic [17:0] e;
   logic        rd_req = 1'b0;
   logic        rd_pend = 1'b0;

   always #5 clk = ~clk;

   scope_capture #(.ADDR_W(9), .PRETRIG(64), .TIMEOUT(100)) dut (
      .clk(clk), .reset(reset), .sampleclk(sampleclk), .snd_l(snd_l), .snd_r(snd_r),
      .ch_sel(ch_sel), .trig_level(trig_level), .trig_rising(trig_rising), .arm(arm),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .auto_trig(auto_trig)
   );

   scope_capture #(.ADDR_W(9), .PRETRIG(64), .TIMEOUT(468)) dut_w (
      .clk(clk), .reset(reset), .sampleclk(sampleclk), .snd_l(snd_l), .snd_r(snd_r),
      .ch_sel(ch_sel), .trig_level(trig_level), .trig_rising(trig_rising), .arm(arm_w),
      .rd_addr(rd_addr), .rd_data(rd_data_w), .busy(busy_w), .done(done_w),
      .auto_trig(auto_trig_w)
   );

   function automatic void chk(string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endfunction

   // read scoreboard: response appears one cycle after the address
   always @(posedge clk) rd_pend <= rd_req;

   always @(negedge clk) begin
      if (rd_pend) begin
         if (exp_q.size() == 0) begin
            chk("rd_unexpected", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("rd%s[%0d]", e[17] ? "_w" : "", e[16:8]),
                e[17] ? int'(rd_data_w) : int'(rd_data), int'(e[7:0]));
         end
      end
   end

   task automatic rd(input bit w, input int a, input int exp);
      @(negedge clk);
      rd_addr = 9'(a);
      rd_req  = 1'b1;
      exp_q.push_back({w, 9'(a), 8'(exp)});
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   task automatic send(input int vl, input int vr);
      @(negedge clk);
      snd_l = {8'(vl), 16'hA5C3};
      snd_r = {8'(vr), 16'h5A3C};
      sampleclk = 1'b1;
      repeat (3) @(negedge clk);
      sampleclk = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse_arm(input bit w);
      @(negedge clk);
      if (w) arm_w = 1'b1;
      else   arm   = 1'b1;
      @(negedge clk);
      arm   = 1'b0;
      arm_w = 1'b0;
   endtask

   // 0: ramp -100..100 then hold, 1: ramp 100..-100 then hold,
   // 2: constant 50, 3: sawtooth 0..99
   function automatic int stim(input int kind, input int i);
      int v;
      case (kind)
         0: begin v = -100 + i; if (v > 100) v = 100; end
         1: begin v = 100 - i; if (v < -100) v = -100; end
         2: v = 50;
         default: v = i % 100;
      endcase
      return v;
   endfunction

   task automatic feed(input int kind, input int i);
      int v;
      v = stim(kind, i);
      if (ch_sel) send(-v, v);
      else        send(v, -v);
   endtask

   task automatic run(input int kind, input bit w, input int exp_n, input string nm,
                      input bit inject_arm);
      int n;
      n = -1;
      for (int i = 0; i < 1200; i++) begin
         feed(kind, i);
         if (inject_arm && i == 70) begin
            pulse_arm(1'b0);
            chk({nm, "_busy_after_arm"}, int'(busy), 1);
         end
         if ((w ? done_w : done) == 1'b1) begin
            n = i + 1;
            break;
         end
      end
      chk({nm, "_ticks_to_done"}, n, exp_n);
   endtask

   initial begin
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_auto", int'(auto_trig), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      chk("rst_busy_w", int'(busy_w), 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // rising trigger on left, with an ignored arm in WAIT
      ch_sel = 1'b0; trig_rising = 1'b1; trig_level = 8'd0;
      pulse_arm(1'b0);
      chk("arm_busy", int'(busy), 1);
      run(0, 1'b0, 548, "rise", 1'b1);
      chk("rise_done", int'(done), 1);
      chk("rise_busy", int'(busy), 0);
      chk("rise_auto", int'(auto_trig), 0);
      rd(1'b0, 64, 128);
      rd(1'b0, 63, 127);
      rd(1'b0, 0, 64);
      rd(1'b0, 164, 228);
      rd(1'b0, 511, 228);

      // re-arm from DONE, falling trigger on right
      ch_sel = 1'b1; trig_rising = 1'b0; trig_level = 8'd10;
      pulse_arm(1'b0);
      chk("rearm_done", int'(done), 0);
      chk("rearm_busy", int'(busy), 1);
      run(1, 1'b0, 538, "fall", 1'b0);
      rd(1'b0, 64, 138);
      rd(1'b0, 63, 139);
      rd(1'b0, 0, 202);
      rd(1'b0, 174, 28);

      // auto-trigger after 100 WAIT ticks
      ch_sel = 1'b0; trig_rising = 1'b1; trig_level = 8'd0;
      pulse_arm(1'b0);
      run(2, 1'b0, 612, "tmo", 1'b0);
      chk("tmo_auto", int'(auto_trig), 1);
      chk("tmo_done", int'(done), 1);
      rd(1'b0, 64, 178);
      rd(1'b0, 0, 178);

      // re-arm clears auto_trig; reset mid-POST
      pulse_arm(1'b0);
      chk("rearm_auto_clr", int'(auto_trig), 0);
      for (int i = 0; i < 300; i++) feed(0, i);
      chk("mid_post_busy", int'(busy), 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_auto", int'(auto_trig), 0);
      chk("midrst_rd_data", int'(rd_data), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      pulse_arm(1'b0);
      run(0, 1'b0, 548, "post_rst", 1'b0);
      rd(1'b0, 64, 128);
      rd(1'b0, 100, 164);

      // forced trigger at physical 20: frame wraps the buffer
      pulse_arm(1'b1);
      run(3, 1'b1, 980, "wrap", 1'b0);
      chk("wrap_auto", int'(auto_trig_w), 1);
      rd(1'b1, 0, 196);
      rd(1'b1, 43, 139);
      rd(1'b1, 44, 140);
      rd(1'b1, 64, 160);
      rd(1'b1, 511, 207);

      repeat (3) @(negedge clk);
      chk("scoreboard_left", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1);
   end

endmodule
